// File: rtl/note_sequencer_pkg.sv
// Shared types and constants for the music-box note sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//   state_e        sequencer FSM states
//   NOTE_W, DUR_W  note-mask and duration field widths of a song ROM word {dur, mask}
//   END_MARKER_DUR duration value that terminates a song
//   N_1C..N_3B     bit index of each note line on play_note
package note_seq_pkg;

    localparam int NOTE_W = 21;
    localparam int DUR_W  = 8;

    localparam logic [DUR_W-1:0] END_MARKER_DUR = '0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LATCH   = 3'd2,
        PLAY    = 3'd3,
        GAP     = 3'd4,
        ADVANCE = 3'd5,
        END     = 3'd6
    } state_e;

    // Three octaves of naturals, lowest note in bit 0.
    localparam int N_1C = 0;
    localparam int N_1D = 1;
    localparam int N_1E = 2;
    localparam int N_1F = 3;
    localparam int N_1G = 4;
    localparam int N_1A = 5;
    localparam int N_1B = 6;
    localparam int N_2C = 7;
    localparam int N_2D = 8;
    localparam int N_2E = 9;
    localparam int N_2F = 10;
    localparam int N_2G = 11;
    localparam int N_2A = 12;
    localparam int N_2B = 13;
    localparam int N_3C = 14;
    localparam int N_3D = 15;
    localparam int N_3E = 16;
    localparam int N_3F = 17;
    localparam int N_3G = 18;
    localparam int N_3A = 19;
    localparam int N_3B = 20;

endpackage

// File: rtl/note_sequencer_tick_prescaler.sv
// Tick prescaler: counts 0..TICK_DIV-1 and pulses tick on the terminal count.
// Latency: tick is combinational from the count register (one pulse every TICK_DIV unheld cycles).
// Backpressure: hold freezes the count and suppresses tick; clear forces the count to 0.
//   clock, reset  system clock, asynchronous active-high reset
//   clear         synchronous clear (wins over hold)
//   hold          freeze while high
//   tick          one-cycle pulse at the terminal count
module tick_prescaler #(
    parameter int TICK_DIV = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int                CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  TERM  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A held terminal count must not tick repeatedly, so hold gates tick too.
    assign tick = (cnt_q == TERM) && !hold && !clear;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Music-box sequencer: plays {dur, mask} entries from a synchronous song ROM onto the
// oscillator play lines, with a silent gap after each note, OR-merged with live keys.
// Latency: live keys 1 cycle; first note 3 edges after start; 3 cycles between notes.
// Backpressure: none; pause freezes timing in PLAY/GAP, stop aborts to IDLE.
// Ports: clock/reset (async active-high), start/stop pulses, pause level, key_in live keys,
//   rom_addr/rom_data song ROM (data valid 1 cycle after address), play_note play lines,
//   busy (not IDLE), done (one-cycle pulse at song end).
// Build option NOTE_SEQUENCER_LOOP_EN: song end restarts at address 0 instead of stopping;
//   done still pulses once per pass and busy stays high until stop.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int TICK_DIV  = 500000,
    parameter int GAP_TICKS = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    pause,
    input  logic [NOTE_W-1:0]       key_in,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DUR_W+NOTE_W-1:0] rom_data,
    output logic [NOTE_W-1:0]       play_note,
    output logic                    busy,
    output logic                    done
);

    state_e              state_q,    state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [NOTE_W-1:0]   seq_mask_q, seq_mask_d;
    logic [NOTE_W-1:0]   key_reg_q,  key_reg_d;
    logic [DUR_W-1:0]    dur_cnt_q,  dur_cnt_d;
    logic                done_q,     done_d;

    logic                tick;
    logic [DUR_W-1:0]    rom_dur;
    logic [NOTE_W-1:0]   rom_mask;

    assign rom_dur  = rom_data[NOTE_W +: DUR_W];
    assign rom_mask = rom_data[NOTE_W-1:0];

    // Prescaler restarts in LATCH so every note starts on a full tick period.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (state_q == LATCH),
        .hold  (pause),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        seq_mask_d = seq_mask_q;
        dur_cnt_d  = dur_cnt_q;
        done_d     = 1'b0;
        key_reg_d  = key_in;

        case (state_q)
            IDLE: begin
                seq_mask_d = '0;
                rom_addr_d = '0;
                if (start) state_d = FETCH;
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                if (rom_dur == END_MARKER_DUR) begin
                    done_d     = 1'b1;
                    seq_mask_d = '0;
`ifdef NOTE_SEQUENCER_LOOP_EN
                    rom_addr_d = '0;
                    state_d    = FETCH;
`else
                    state_d    = END;
`endif
                end else begin
                    seq_mask_d = rom_mask;
                    dur_cnt_d  = rom_dur;
                    state_d    = PLAY;
                end
            end
            // tick is suppressed while paused, which freezes PLAY/GAP in place.
            PLAY: begin
                if (tick) begin
                    if (dur_cnt_q == DUR_W'(1)) begin
                        if (GAP_TICKS > 0) begin
                            seq_mask_d = '0;
                            dur_cnt_d  = DUR_W'(GAP_TICKS);
                            state_d    = GAP;
                        end else begin
                            dur_cnt_d  = '0;
                            state_d    = ADVANCE;
                        end
                    end else begin
                        dur_cnt_d = dur_cnt_q - DUR_W'(1);
                    end
                end
            end
            GAP: begin
                seq_mask_d = '0;
                if (tick) begin
                    dur_cnt_d = dur_cnt_q - DUR_W'(1);
                    if (dur_cnt_q == DUR_W'(1)) state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                seq_mask_d = '0;
                if (&rom_addr_q) begin
                    // Song ran off the end of the ROM without an end marker.
                    done_d     = 1'b1;
`ifdef NOTE_SEQUENCER_LOOP_EN
                    rom_addr_d = '0;
                    state_d    = FETCH;
`else
                    state_d    = END;
`endif
                end else begin
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    state_d    = FETCH;
                end
            end
            END: begin
                seq_mask_d = '0;
                rom_addr_d = '0;
                state_d    = IDLE;
            end
            default: begin
                seq_mask_d = '0;
                rom_addr_d = '0;
                state_d    = IDLE;
            end
        endcase

        // stop beats everything, including a simultaneous start, and never reports done.
        if (stop) begin
            state_d    = IDLE;
            seq_mask_d = '0;
            rom_addr_d = '0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            seq_mask_q <= '0;
            key_reg_q  <= '0;
            dur_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            seq_mask_q <= seq_mask_d;
            key_reg_q  <= key_reg_d;
            dur_cnt_q  <= dur_cnt_d;
            done_q     <= done_d;
        end
    end

    assign play_note = seq_mask_q | key_reg_q;
    assign rom_addr  = rom_addr_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_DIV=4, GAP_TICKS=1 and a 3-entry song:
// [0]={3, 1C}, [1]={2, 2C|3C}, [2]=end marker. Outputs are checked at falling edges.
module tb_note_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic        pause = 1'b0;
    logic [20:0] key_in = '0;
    logic [7:0]  rom_addr;
    logic [28:0] rom_data = '0;
    logic [20:0] play_note;
    logic        busy;
    logic        done;

    logic [28:0] rom [256];

    int checks = 0;
    int errors = 0;

`ifdef NOTE_SEQUENCER_LOOP_EN
    localparam int SONG_LAST = 75;
`else
    localparam int SONG_LAST = 37;
`endif

    note_sequencer #(
        .ADDR_W    (8),
        .TICK_DIV  (4),
        .GAP_TICKS (1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .key_in    (key_in),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .play_note (play_note),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    // Synchronous song ROM: data follows the address by one clock.
    always @(posedge clock) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs j cycles after the edge that sampled start (j=0 is FETCH).
    // Note 0 sounds after edges 2..13, gap 14..17, ADVANCE/FETCH/LATCH 18..20,
    // note 1 after 21..28, gap 29..32, ADVANCE/FETCH/LATCH 33..35, END at 36.
    task automatic exp_at(input int j, output logic [20:0] m, output logic b,
                          output logic d, output logic [7:0] a);
        int jj;
`ifdef NOTE_SEQUENCER_LOOP_EN
        jj = j % 36;
        b  = 1'b1;
        d  = (j > 0) && (jj == 0);
`else
        jj = j;
        b  = (j <= 36);
        d  = (j == 36);
`endif
        m = (jj >= 2 && jj <= 13)  ? 21'h000001 :
            (jj >= 21 && jj <= 28) ? 21'h004080 : 21'h0;
        a = (jj >= 19 && jj <= 33) ? 8'd1 :
            (jj >= 34 && jj <= 36) ? 8'd2 : 8'd0;
    endtask

    // Plays the song from IDLE, checking every cycle; extra_j re-pulses start while busy.
    task automatic run_song(input string tag, input int extra_j, input logic [20:0] key);
        logic [20:0] m;
        logic        b;
        logic        d;
        logic [7:0]  a;
        start = 1'b1;
        for (int j = 0; j <= SONG_LAST; j++) begin
            @(negedge clock);
            start = (j == extra_j);
            exp_at(j, m, b, d, a);
            chk({tag, "_note"}, 32'(play_note), 32'(m | key));
            chk({tag, "_busy"}, 32'(busy), 32'(b));
            chk({tag, "_done"}, 32'(done), 32'(d));
            chk({tag, "_addr"}, 32'(rom_addr), 32'(a));
        end
    endtask

    task automatic pulse_stop(input string tag);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        chk({tag, "_stop_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rom[0] = {8'd3, 21'h000001};
        rom[1] = {8'd2, 21'h004080};
        rom[2] = {8'd0, 21'h1FFFFF};

        // Reset state.
        #1 reset = 1'b1;
        #2;
        chk("rst_note", 32'(play_note), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_busy", 32'(busy), 32'd0);

        // Scenario 1: plain playback to the natural end.
        run_song("s1", -1, 21'h0);
        pulse_stop("s1");

        // Scenario 2: a live key is merged onto the play lines with one cycle of latency.
        key_in = 21'h100000;
        chk("key_lat0", 32'(play_note), 32'd0);
        @(negedge clock);
        chk("key_lat1", 32'(play_note), 32'h100000);
        run_song("s2", -1, 21'h100000);
        pulse_stop("s2");
        key_in = 21'h0;
        @(negedge clock);
        chk("key_off", 32'(play_note), 32'd0);

        // Scenario 3: pause sampled on 10 edges mid note 0 stretches it to 22 cycles.
        start = 1'b1;
        for (int j = 0; j <= 26; j++) begin
            @(negedge clock);
            start = 1'b0;
            pause = (j >= 5 && j <= 14);
            chk("s3_note", 32'(play_note), (j >= 2 && j <= 23) ? 32'h1 : 32'h0);
            chk("s3_busy", 32'(busy), 32'd1);
        end
        pause = 1'b0;
        pulse_stop("s3");

        // Scenario 4: stop during note 1 aborts silently; start then replays from 0.
        start = 1'b1;
        for (int j = 0; j <= 24; j++) begin
            @(negedge clock);
            start = 1'b0;
            if (j == 22) chk("s4_note1", 32'(play_note), 32'h4080);
        end
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        chk("s4_note", 32'(play_note), 32'd0);
        chk("s4_busy", 32'(busy), 32'd0);
        chk("s4_addr", 32'(rom_addr), 32'd0);
        chk("s4_done", 32'(done), 32'd0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            chk("s4_nodone", 32'(done), 32'd0);
            chk("s4_idle", 32'(busy), 32'd0);
        end
        run_song("s4r", -1, 21'h0);
        pulse_stop("s4r");

        // Scenario 5: start+stop together in IDLE stays idle; start while busy is ignored.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        stop  = 1'b0;
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_addr", 32'(rom_addr), 32'd0);
        @(negedge clock);
        chk("s5_busy2", 32'(busy), 32'd0);
        chk("s5_note", 32'(play_note), 32'd0);
        run_song("s5", 5, 21'h0);
        pulse_stop("s5");

        // Scenario 6: reset mid-note clears outputs without waiting for a clock edge.
        key_in = 21'h100000;
        start  = 1'b1;
        for (int j = 0; j <= 5; j++) begin
            @(negedge clock);
            start = 1'b0;
        end
        chk("s6_pre", 32'(play_note), 32'h100001);
        #2 reset = 1'b1;
        #1;
        chk("s6_note", 32'(play_note), 32'd0);
        chk("s6_busy", 32'(busy), 32'd0);
        chk("s6_addr", 32'(rom_addr), 32'd0);
        @(negedge clock);
        reset  = 1'b0;
        key_in = 21'h0;
        @(negedge clock);
        chk("s6_after", 32'(play_note), 32'd0);
        chk("s6_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
